// File: rtl/register_file_n.sv
// Parametrised register file with DEPTH words of WIDTH bits, one byte-enabled write port and
// two combinational read ports, with an optional hardwired-zero register 0 and write-to-read bypass.
module register_file_n #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    localparam int NB = WIDTH / 8;

    // Every address must map onto a real register, so DEPTH must fill the address space exactly.
    if ((WIDTH % 8 != 0) || (DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_bad_params
        $error("register_file_n: illegal WIDTH/DEPTH/ADDR_W combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wr_merge;
    logic             wr_en;
    logic             byp_a;
    logic             byp_b;
    logic             zero_a;
    logic             zero_b;

    // Writes aimed at the hardwired-zero register are dropped before they reach storage.
    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // The word as it will look after the edge: enabled bytes from wdata, the rest from storage.
    always_comb begin
        // NOTE: default first so every bit is assigned on every path and no latch is inferred.
        wr_merge = mem[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                wr_merge[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Bypass is gated by reset so a held write cannot leak onto the read ports while cleared.
    assign byp_a  = (BYPASS != 0) && reset && wr_en && (raddr_a == waddr);
    assign byp_b  = (BYPASS != 0) && reset && wr_en && (raddr_b == waddr);
    assign zero_a = (ZERO_REG != 0) && (raddr_a == '0);
    assign zero_b = (ZERO_REG != 0) && (raddr_b == '0);

    assign rdata_a = zero_a ? '0 : (byp_a ? wr_merge : mem[raddr_a]);
    assign rdata_b = zero_b ? '0 : (byp_b ? wr_merge : mem[raddr_b]);

endmodule

// File: tb/tb_register_file_n.sv
// Self-checking bench for register_file_n: default, no-bypass and 16-bit/8-deep instances
// compared against a word-array reference model.
`timescale 1ns/100ps
module tb_register_file_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;

    logic        we_s = 1'b0;
    logic [2:0]  waddr_s = '0;
    logic [15:0] wdata_s = '0;
    logic [1:0]  wbe_s = '0;
    logic [2:0]  raddr_a_s = '0;
    logic [2:0]  raddr_b_s = '0;
    logic [15:0] rdata_a_s, rdata_b_s;

    int errors = 0;
    int checks = 0;

    logic [31:0] model   [32];
    logic [15:0] model_s [8];

    always #5 clk = ~clk;

    register_file_n dut_byp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0)
    );

    register_file_n #(.BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1)
    );

    register_file_n #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dut_small (
        .clk(clk), .reset(reset), .we(we_s), .waddr(waddr_s), .wdata(wdata_s), .wbe(wbe_s),
        .raddr_a(raddr_a_s), .rdata_a(rdata_a_s), .raddr_b(raddr_b_s), .rdata_b(rdata_b_s)
    );

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] nw,
                                            input logic [1:0] be);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Expected read of the 32-bit instances given the currently driven inputs.
    function automatic logic [31:0] exp_big(input logic [4:0] a, input bit byp);
        if (!reset || a == 5'd0) return 32'h0;
        if (byp && we && a == waddr) return merge32(model[a], wdata, wbe);
        return model[a];
    endfunction

    task automatic setup(input logic we_i, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        we = we_i; waddr = wa; wdata = wd; wbe = be; raddr_a = ra; raddr_b = rb;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (reset && we && waddr != 5'd0) model[waddr] = merge32(model[waddr], wdata, wbe);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs [4];
        #3 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 8; i++) model_s[i] = '0;
        for (int a = 0; a < 32; a++) begin
            raddr_a = 5'(a); raddr_b = 5'(31 - a);
            #1;
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_clear addr=%0d port=%0d: got %h expected 00000000", a, k, obs[k]);
                end
            end
        end
        setup(1'b1, 5'd5, 32'h6FFFFFFF, 4'hF, 5'd5, 5'd5);
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_blocks_write phase=%0d port=%0d: got %h expected 00000000", phase, k, obs[k]);
                end
            end
            if (phase == 0) commit();
        end
        setup(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
        reset = 1'b1;
    endtask

    task automatic test_full_write();
        logic [31:0] obs [4];
        logic [31:0] exp;
        for (int n = 1; n < 32; n++) begin
            setup(1'b1, 5'(n), 32'h0088140A + 32'(n), 4'hF, 5'd0, 5'd0);
            commit();
        end
        for (int n = 0; n < 32; n++) begin
            setup(1'b0, 5'd0, 32'h0, 4'h0, 5'(n), 5'(31 - n));
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                if (k % 2 == 0) exp = (n == 0) ? 32'h0 : 32'h0088140A + 32'(n);
                else            exp = (n == 31) ? 32'h0 : 32'h0088140A + 32'(31 - n);
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("FAIL full_readback n=%0d port=%0d: got %h expected %h", n, k, obs[k], exp);
                end
            end
        end
        setup(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL zero_reg phase=%0d port=%0d: got %h expected 00000000", phase, k, obs[k]);
                end
            end
            if (phase == 0) commit();
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] obs [4];
        setup(1'b1, 5'd5, 32'hAAAAAA88, 4'hF, 5'd5, 5'd5);
        commit();
        setup(1'b1, 5'd5, 32'h2288140A, 4'b0101, 5'd5, 5'd5);
        commit();
        setup(1'b1, 5'd5, 32'h12345678, 4'b0000, 5'd5, 5'd5);
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== 32'hAA88AA0A) begin
                    errors++;
                    $display("FAIL byte_enable phase=%0d port=%0d: got %h expected aa88aa0a", phase, k, obs[k]);
                end
            end
            if (phase == 0) commit();
        end
    endtask

    task automatic test_bypass();
        logic [31:0] obs [4];
        logic [31:0] exp [4];
        setup(1'b1, 5'd7, 32'h11111111, 4'hF, 5'd0, 5'd0);
        commit();
        setup(1'b1, 5'd7, 32'h33333333, 4'b0011, 5'd7, 5'd7);
        exp = '{32'h11113333, 32'h11113333, 32'h11111111, 32'h11111111};
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL bypass phase=%0d port=%0d: got %h expected %h", phase, k, obs[k], exp[k]);
                end
            end
            if (phase == 0) commit();
            exp = '{32'h11113333, 32'h11113333, 32'h11113333, 32'h11113333};
        end
    endtask

    task automatic test_random();
        logic [31:0] obs [4];
        logic [31:0] exp [4];
        logic [4:0]  wa;
        for (int it = 0; it < 250; it++) begin
            wa = 5'($urandom);
            setup(1'($urandom), wa, $urandom, 4'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom));
            for (int phase = 0; phase < 2; phase++) begin
                obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
                exp = '{exp_big(raddr_a, 1'b1), exp_big(raddr_b, 1'b1),
                        exp_big(raddr_a, 1'b0), exp_big(raddr_b, 1'b0)};
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (obs[k] !== exp[k]) begin
                        errors++;
                        $display("FAIL random it=%0d phase=%0d port=%0d ra=%0d rb=%0d: got %h expected %h",
                                 it, phase, k, raddr_a, raddr_b, obs[k], exp[k]);
                    end
                end
                if (phase == 0) commit();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs [4];
        logic [31:0] exp [4];
        logic [31:0] wd;
        wd = $urandom | 32'h1;
        setup(1'b1, 5'd9, wd, 4'hF, 5'd9, 5'd3);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_s = '{default: '0};
        #1;
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_mid_clear phase=%0d port=%0d: got %h expected 00000000", phase, k, obs[k]);
                end
            end
            if (phase == 0) commit();
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp = '{wd, 32'h0, 32'h0, 32'h0};
        for (int phase = 0; phase < 2; phase++) begin
            obs = '{rdata_a0, rdata_b0, rdata_a1, rdata_b1};
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL reset_mid_resume phase=%0d port=%0d: got %h expected %h", phase, k, obs[k], exp[k]);
                end
            end
            if (phase == 0) commit();
            exp = '{wd, 32'h0, wd, 32'h0};
        end
        setup(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    endtask

    task automatic test_param_sweep();
        logic [15:0] wd [3]  = '{16'hC0C0, 16'h1234, 16'hABCD};
        logic [1:0]  be [3]  = '{2'b11, 2'b01, 2'b10};
        logic [15:0] exp [3] = '{16'hC0C0, 16'hC034, 16'hAB34};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            we_s = 1'b1; waddr_s = 3'd0; wdata_s = wd[s]; wbe_s = be[s];
            raddr_a_s = 3'd0; raddr_b_s = 3'd0;
            #1;
            for (int phase = 0; phase < 2; phase++) begin
                checks += 2;
                if (rdata_a_s !== exp[s] || rdata_b_s !== exp[s]) begin
                    errors++;
                    $display("FAIL small_reg0 step=%0d phase=%0d: got a=%h b=%h expected %h",
                             s, phase, rdata_a_s, rdata_b_s, exp[s]);
                end
                if (phase == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        model_s[0] = 16'hAB34;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            we_s = 1'b1; waddr_s = 3'($urandom); wdata_s = 16'($urandom); wbe_s = 2'($urandom);
            @(posedge clk);
            model_s[waddr_s] = merge16(model_s[waddr_s], wdata_s, wbe_s);
        end
        @(negedge clk);
        we_s = 1'b0;
        for (int a = 0; a < 8; a++) begin
            raddr_a_s = 3'(a); raddr_b_s = 3'(7 - a);
            #1;
            checks += 2;
            if (rdata_a_s !== model_s[a] || rdata_b_s !== model_s[7 - a]) begin
                errors++;
                $display("FAIL small_readback a=%0d: got a=%h b=%h expected a=%h b=%h",
                         a, rdata_a_s, rdata_b_s, model_s[a], model_s[7 - a]);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_write();
        test_byte_enables();
        test_bypass();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
